// File: rtl/osram_arbiter.sv
// Round-robin arbiter serialising two requesters onto one SRAM port; strobes held ACCESS_CYCLES, Ack one cycle later.
// Requests wait (Req held high) while an access is in flight; nothing is dropped.
module osram_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 16
) (
  input  logic              clk2,
  input  logic              NReset,
  input  logic              Req0,
  input  logic              Wr0,
  input  logic [ADDR_W-1:0] Add0,
  input  logic [DATA_W-1:0] Wdata0,
  output logic              Ack0,
  output logic [DATA_W-1:0] Rdata0,
  input  logic              Req1,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Add1,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata1,
  output logic [ADDR_W-1:0] OSAdd,
  output logic [DATA_W-1:0] OSDataout,
  input  logic [DATA_W-1:0] OSDatain,
  output logic              OSRead,
  output logic              OSWrite
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                ptr_q, ptr_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // With a single requester Req1 alone selects; with both the pointer decides.
    pick     = (Req0 && Req1) ? ptr_q : Req1;

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          gnt_d   = pick;
          wr_d    = pick ? Wr1 : Wr0;
          addr_d  = pick ? Add1 : Add0;
          wdata_d = pick ? Wdata1 : Wdata0;
          cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) begin
            if (gnt_q) rdata1_d = OSDatain;
            else       rdata0_d = OSDatain;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      ptr_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode flops only, so the async reset drops the strobes immediately.
  assign OSRead    = (state_q == ACCESS) && !wr_q;
  assign OSWrite   = (state_q == ACCESS) && wr_q;
  assign OSAdd     = addr_q;
  assign OSDataout = ((state_q == ACCESS) && wr_q) ? wdata_q : '0;
  assign Ack0      = (state_q == DONE) && !gnt_q;
  assign Ack1      = (state_q == DONE) && gnt_q;
  assign Rdata0    = rdata0_q;
  assign Rdata1    = rdata1_q;

endmodule

// File: tb/tb_osram_arbiter.sv
// Bench for osram_arbiter: two instances (ACCESS_CYCLES 1 and 4) with SRAM models, checked per cycle
// against a transaction-timeline reference model.
module tb_osram_arbiter;

  localparam int AC0 = 1;
  localparam int AC1 = 4;

  logic        clk;
  logic        nreset;
  logic        req0 [2];
  logic        wr0 [2];
  logic [11:0] add0 [2];
  logic [15:0] wdata0 [2];
  logic        ack0 [2];
  logic [15:0] rdata0 [2];
  logic        req1 [2];
  logic        wr1 [2];
  logic [11:0] add1 [2];
  logic [15:0] wdata1 [2];
  logic        ack1 [2];
  logic [15:0] rdata1 [2];
  logic [11:0] osadd [2];
  logic [15:0] osdo [2];
  logic [15:0] osdi [2];
  logic        osrd [2];
  logic        oswr [2];

  logic [15:0] mem [2][4096];
  logic        mem_clr;
  logic        pl_en;
  logic        pl_g;
  logic [11:0] pl_a;
  logic [15:0] pl_d;

  // Reference state
  logic [15:0] refmem [2][4096];
  logic [15:0] rd_m [2][2];
  int          ptr_m [2];
  logic [11:0] last_addr_m [2];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    osram_arbiter #(.ACCESS_CYCLES(g == 0 ? AC0 : AC1)) u_dut (
      .clk2      (clk),
      .NReset    (nreset),
      .Req0      (req0[g]),
      .Wr0       (wr0[g]),
      .Add0      (add0[g]),
      .Wdata0    (wdata0[g]),
      .Ack0      (ack0[g]),
      .Rdata0    (rdata0[g]),
      .Req1      (req1[g]),
      .Wr1       (wr1[g]),
      .Add1      (add1[g]),
      .Wdata1    (wdata1[g]),
      .Ack1      (ack1[g]),
      .Rdata1    (rdata1[g]),
      .OSAdd     (osadd[g]),
      .OSDataout (osdo[g]),
      .OSDatain  (osdi[g]),
      .OSRead    (osrd[g]),
      .OSWrite   (oswr[g])
    );
    assign osdi[g] = osrd[g] ? mem[g][osadd[g]] : 16'hDEAD;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int g = 0; g < 2; g++)
        for (int a = 0; a < 4096; a++) mem[g][a] <= 16'h0000;
    end else begin
      if (pl_en) mem[pl_g][pl_a] <= pl_d;
      for (int g = 0; g < 2; g++)
        if (oswr[g]) mem[g][osadd[g]] <= osdo[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int g = 0; g < 2; g++) begin
      ptr_m[g]       = 0;
      last_addr_m[g] = 12'h000;
      rd_m[g][0]     = 16'h0000;
      rd_m[g][1]     = 16'h0000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_osread_i%0d", tag, g), 32'(osrd[g]), 32'd0);
      chk($sformatf("%s_oswrite_i%0d", tag, g), 32'(oswr[g]), 32'd0);
      chk($sformatf("%s_osadd_i%0d", tag, g), 32'(osadd[g]), 32'd0);
      chk($sformatf("%s_osdataout_i%0d", tag, g), 32'(osdo[g]), 32'd0);
      chk($sformatf("%s_ack0_i%0d", tag, g), 32'(ack0[g]), 32'd0);
      chk($sformatf("%s_ack1_i%0d", tag, g), 32'(ack1[g]), 32'd0);
      chk($sformatf("%s_rdata0_i%0d", tag, g), 32'(rdata0[g]), 32'd0);
      chk($sformatf("%s_rdata1_i%0d", tag, g), 32'(rdata1[g]), 32'd0);
    end
  endtask

  task automatic preload(input int g, input logic [11:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_g = 1'(g); pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
    refmem[g][a] = d;
  endtask

  // One arbitration round starting from IDLE at a falling edge. The expected
  // timeline follows the timing rules: first grant strobes k=1..AC, Ack at AC+1,
  // one IDLE cycle, second grant strobes AC+3..2AC+2, Ack at 2AC+3.
  task automatic step(input int g,
                      input bit r0, input bit w0, input logic [11:0] a0, input logic [15:0] d0,
                      input bit r1, input bit w1, input logic [11:0] a1, input logic [15:0] d1,
                      input bit scr);
    bit          wq [2];
    logic [11:0] aq [2];
    logic [15:0] dq [2];
    int first, second, ac, len, cur, ak;
    bit e_rd, e_wr;
    string t;
    wq = '{w0, w1}; aq = '{a0, a1}; dq = '{d0, d1};
    ac = (g == 0) ? AC0 : AC1;
    req0[g] = r0; wr0[g] = w0; add0[g] = a0; wdata0[g] = d0;
    req1[g] = r1; wr1[g] = w1; add1[g] = a1; wdata1[g] = d1;
    first = -1; second = -1;
    if (r0 && r1) begin first = ptr_m[g]; second = 1 - first; end
    else if (r0) first = 0;
    else if (r1) first = 1;
    len = (first < 0) ? 2 : ((second < 0) ? ac + 2 : 2 * ac + 4);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      t = $sformatf("i%0d_k%0d", g, k);
      cur = -1; ak = -1;
      if (first >= 0 && k <= ac) cur = first;
      if (second >= 0 && k >= ac + 3 && k <= 2 * ac + 2) cur = second;
      if (first >= 0 && k == ac + 1) ak = first;
      if (second >= 0 && k == 2 * ac + 3) ak = second;
      if (first >= 0 && k == 1) last_addr_m[g] = aq[first];
      if (second >= 0 && k == ac + 3) last_addr_m[g] = aq[second];
      if (ak >= 0) begin
        if (wq[ak]) refmem[g][aq[ak]] = dq[ak];
        else        rd_m[g][ak] = refmem[g][aq[ak]];
        ptr_m[g] = 1 - ak;
      end
      e_rd = 1'b0; e_wr = 1'b0;
      if (cur >= 0) begin
        e_rd = !wq[cur];
        e_wr = wq[cur];
        chk({t, "_osdataout"}, 32'(osdo[g]), wq[cur] ? 32'(dq[cur]) : 32'd0);
      end
      chk({t, "_osread"}, 32'(osrd[g]), 32'(e_rd));
      chk({t, "_oswrite"}, 32'(oswr[g]), 32'(e_wr));
      chk({t, "_osadd"}, 32'(osadd[g]), 32'(last_addr_m[g]));
      chk({t, "_ack0"}, 32'(ack0[g]), 32'(ak == 0));
      chk({t, "_ack1"}, 32'(ack1[g]), 32'(ak == 1));
      chk({t, "_rdata0"}, 32'(rdata0[g]), 32'(rd_m[g][0]));
      chk({t, "_rdata1"}, 32'(rdata1[g]), 32'(rd_m[g][1]));
      if (ak == 0) req0[g] = 1'b0;
      if (ak == 1) req1[g] = 1'b0;
      // Fields of the granted requester are already latched; disturb them.
      if (scr && k == 1 && first == 0) begin add0[g] = ~a0; wdata0[g] = ~d0; end
      if (scr && k == 1 && first == 1) begin add1[g] = ~a1; wdata1[g] = ~d1; end
    end
  endtask

  function automatic logic [11:0] raddr();
    if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 15));
    return 12'(32'hFF0 + $urandom_range(0, 15));
  endfunction

  initial begin
    bit          r0, r1, w0, w1, scr;
    checks = 0; failures = 0;
    nreset = 1'b0; mem_clr = 1'b1; pl_en = 1'b0; pl_g = 1'b0; pl_a = '0; pl_d = '0;
    for (int g = 0; g < 2; g++) begin
      req0[g] = 1'b0; wr0[g] = 1'b0; add0[g] = '0; wdata0[g] = '0;
      req1[g] = 1'b0; wr1[g] = 1'b0; add1[g] = '0; wdata1[g] = '0;
      for (int a = 0; a < 4096; a++) refmem[g][a] = 16'h0000;
    end
    reset_model();
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    check_reset_outputs("reset");
    preload(0, 12'h010, 16'hBEEF);
    preload(1, 12'h010, 16'hBEEF);
    nreset = 1'b1;
    @(negedge clk);

    // Single read on the 1-cycle instance
    step(0, 1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    // Requester 1 write then read-back at the top address
    step(0, 0, 0, 12'h000, 16'h0000, 1, 1, 12'hFFF, 16'h1234, 0);
    step(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'hFFF, 16'h0000, 0);
    // Simultaneous requests alternate 0,1,0,1
    step(0, 1, 0, 12'h010, 16'h0000, 1, 0, 12'hFFF, 16'h0000, 0);
    step(0, 1, 1, 12'h005, 16'h5555, 1, 1, 12'h006, 16'h6666, 0);
    // Four-cycle read with address disturbed after the grant
    step(1, 1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000, 1);

    // Reset during the second ACCESS cycle of a write
    req0[1] = 1'b1; wr0[1] = 1'b1; add0[1] = 12'h123; wdata0[1] = 16'hA5A5;
    @(negedge clk);
    chk("rst_write_strobe", 32'(oswr[1]), 32'd1);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    refmem[1][12'h123] = 16'hA5A5;
    reset_model();
    check_reset_outputs("midreset");
    req0[1] = 1'b0;
    @(negedge clk);
    chk("midreset_no_ack0", 32'(ack0[1]), 32'd0);
    chk("midreset_no_write", 32'(oswr[1]), 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    step(1, 1, 0, 12'h123, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    step(1, 1, 1, 12'hFFF, 16'h0F0F, 1, 0, 12'hFFF, 16'h0000, 0);

    // Randomized rounds on both instances
    for (int i = 0; i < 40; i++) begin
      r0  = 1'($urandom_range(0, 1));
      r1  = 1'($urandom_range(0, 1));
      w0  = 1'($urandom_range(0, 1));
      w1  = 1'($urandom_range(0, 1));
      scr = 1'($urandom_range(0, 1));
      step(i % 2, r0, w0, raddr(), 16'($urandom), r1, w1, raddr(), 16'($urandom), scr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osram_arbiter.md
Name: osram_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the 4K x 16 on-chip SRAM.
- Accepts independent read/write requests and serialises them onto the single OSRead/OSWrite/OSAdd/OSDataout/OSDatain port.
- Holds the SRAM strobes for a programmable number of cycles.
- Returns per-requester registered read data with a one-cycle Ack.
- Sits between the datapath masters (e.g. DMA/encoder side and host side) and the SRAM wrapper.

Parameters:
ACCESS_CYCLES, 1, cycles the SRAM strobe is held per access; legal range 1..15.
ADDR_W, 12, SRAM word-address width; fixed at 12 for this SRAM.
DATA_W, 16, SRAM data width; fixed at 16.

Ports:
clk2  input  1  system clock, rising edge
NReset  input  1  asynchronous active-low reset
Req0  input  1  requester 0 access request; held until Ack0
Wr0  input  1  requester 0 direction: 1 = write, 0 = read
Add0  input  12  requester 0 word address
Wdata0  input  16  requester 0 write data
Ack0  output  1  requester 0 access complete; one-cycle pulse
Rdata0  output  16  requester 0 read data, registered
Req1, Wr1, Add1, Wdata1, Ack1, Rdata1: same as requester 0, for requester 1
OSAdd  output  12  SRAM address
OSDataout  output  16  SRAM write data (into SRAM)
OSDatain  input  16  SRAM read data (from SRAM); valid while OSRead is high
OSRead  output  1  SRAM read strobe
OSWrite  output  1  SRAM write strobe

Behaviour:
Clocking and reset:
- Single clock clk2; NReset asynchronous, active-low.
- Reset values: OSRead=0, OSWrite=0, OSAdd=0, OSDataout=0, Ack0=Ack1=0, Rdata0=Rdata1=0, state=IDLE, priority pointer=requester 0, count=0.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- Sample Req0/Req1.
- If neither is high, stay in IDLE.
- If only one is high, grant it.
- If both are high, grant the requester the pointer favours; the pointer favours the requester not served last.
- On grant, latch grant id, Wr, Add and Wdata into internal registers; load count=ACCESS_CYCLES-1; go to ACCESS.

ACCESS:
- OSAdd = latched address.
- Write: OSWrite=1, OSDataout = latched wdata.
- Read: OSRead=1, OSDataout=0.
- OSRead and OSWrite are never high together.
- Strobes are high for exactly ACCESS_CYCLES consecutive cycles.
- Decrement count each cycle. In the cycle count==0:
  - if read, capture OSDatain into Rdata of the granted requester;
  - go to DONE.

DONE:
- Strobes low; OSAdd holds its value.
- Ack of the granted requester is high for this single cycle; it is a decode of state and grant id.
- For reads, Rdata is valid in the Ack cycle and holds until that requester's next read completes.
- Rdata of the other requester is unchanged.
- Pointer updates to favour the other requester; go to IDLE.

Requester rules:
- A requester keeps Req, Wr, Add and Wdata stable from assertion until Ack.
- Changes after the grant edge are ignored because the fields are latched.
- A requester drops Req at the clock edge that ends its Ack cycle; Req still high in the next IDLE cycle is a new request.

Timing:
- Request sampled in IDLE at cycle t: strobes in t+1..t+ACCESS_CYCLES; Ack in t+ACCESS_CYCLES+1.
- Minimum spacing between accesses is ACCESS_CYCLES+2 cycles.

Boundary conditions:
- Address 0xFFF is legal; no wrap or increment is performed.
- A request arriving during ACCESS/DONE waits; no request is dropped.
- Starvation-free: with both requesters continuously requesting, grants alternate 0,1,0,1.
- NReset low mid-ACCESS: strobes drop immediately, no Ack is issued, Rdata clears to 0; requesters must re-issue.

Test Plan:
1. Reset then Req0 read Add0=0x010 (SRAM preloaded 0x010=0xBEEF), ACCESS_CYCLES=1 -> OSRead high 1 cycle with OSAdd=0x010; Ack0 high 2 cycles after sample; Rdata0=0xBEEF; Ack1 stays 0.
2. Req1 write Add1=0xFFF, Wdata1=0x1234; then Req1 read 0xFFF -> OSWrite 1 cycle with OSDataout=0x1234; read returns Rdata1=0x1234; Rdata0 unchanged.
3. Req0 and Req1 asserted in the same cycle after reset, held continuously -> grant order 0,1,0,1; Acks 3 cycles apart at ACCESS_CYCLES=1; OSRead/OSWrite never both high.
4. ACCESS_CYCLES=4, single read -> OSRead high exactly 4 consecutive cycles; Ack 5 cycles after the sample edge; Add0 changed after grant does not alter OSAdd.
5. NReset pulsed low during the 2nd ACCESS cycle of a write (ACCESS_CYCLES=4) -> OSWrite drops asynchronously; all outputs return to reset values; no Ack; the next request is granted normally.
